// File: rtl/hard_sector_tracker.sv
// rtl/hard_sector_tracker.sv - hard-sector hole interval classifier, track-mark detector and sector lock tracker
module hard_sector_tracker #(
  parameter int TIMER_WIDTH  = 16,
  parameter int SECTOR_WIDTH = 6,
  parameter int SYNC_STAGES  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cke,
  input  logic                    index,
  input  logic [TIMER_WIDTH-1:0]  threshold,
  input  logic [SECTOR_WIDTH-1:0] sectors,
  output logic [TIMER_WIDTH-1:0]  interval,
  output logic                    interval_valid,
  output logic                    track_mark,
  output logic                    sector_pulse,
  output logic [SECTOR_WIDTH-1:0] sector_num,
  output logic                    locked,
  output logic                    lock_lost,
  output logic                    no_index
);

  typedef enum logic [1:0] {SEARCH = 2'd0, LOCKED = 2'd1, INDEX = 2'd2} state_t;

  localparam logic [TIMER_WIDTH-1:0]  TIMER_MAX  = '1;
  localparam logic [TIMER_WIDTH-1:0]  TIMER_ONE  = TIMER_WIDTH'(1);
  localparam logic [SECTOR_WIDTH-1:0] SECTOR_ONE = SECTOR_WIDTH'(1);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    index_edge;
  logic                    measured;
  logic                    is_long;
  logic                    saturating;
  logic                    drop_lock;
  logic [TIMER_WIDTH-1:0]  timer;
  logic                    first_seen;
  logic [2:0]              history;
  logic [2:0]              history_next;
  logic [SECTOR_WIDTH-1:0] last_sector;
  logic [SECTOR_WIDTH-1:0] sector_num_next;
  logic                    track_mark_next;
  logic                    sector_pulse_next;
  logic                    locked_next;
  logic                    lock_lost_next;
  state_t                  state;
  state_t                  state_next;

  assign index_edge   = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign measured     = index_edge & first_seen;
  // a saturated timer means a hole was missed, so it can never count as short
  assign is_long      = (timer == TIMER_MAX) || (timer > threshold);
  assign history_next = {history[1:0], is_long};
  assign saturating   = !index_edge && cke && (timer == TIMER_MAX - TIMER_ONE);
  assign last_sector  = sectors - SECTOR_ONE;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    drop_lock  = 1'b0;
    if (measured) begin
      case (state)
        SEARCH: begin
          if (history_next == 3'b100) state_next = LOCKED;
        end
        LOCKED: begin
          if (is_long && (sector_num < last_sector)) state_next = LOCKED;
          else if (!is_long && (sector_num == last_sector)) state_next = INDEX;
          else drop_lock = 1'b1;
        end
        INDEX: begin
          if (!is_long) state_next = LOCKED;
          else drop_lock = 1'b1;
        end
        default: drop_lock = 1'b1;
      endcase
    end else if (saturating && (state != SEARCH)) begin
      drop_lock = 1'b1;
    end
    if (drop_lock) state_next = SEARCH;
  end

  always_comb begin
    track_mark_next   = 1'b0;
    sector_pulse_next = 1'b0;
    lock_lost_next    = 1'b0;
    sector_num_next   = sector_num;
    locked_next       = locked;
    if (drop_lock) begin
      locked_next     = 1'b0;
      lock_lost_next  = 1'b1;
      sector_num_next = '0;
    end else if (measured && (state_next == LOCKED)) begin
      sector_pulse_next = 1'b1;
      locked_next       = 1'b1;
      if (state == LOCKED) begin
        sector_num_next = sector_num + SECTOR_ONE;
      end else begin
        sector_num_next = '0;
        track_mark_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q         <= '0;
      timer          <= '0;
      first_seen     <= 1'b0;
      history        <= 3'b000;
      interval       <= '0;
      interval_valid <= 1'b0;
      track_mark     <= 1'b0;
      sector_pulse   <= 1'b0;
      sector_num     <= '0;
      locked         <= 1'b0;
      lock_lost      <= 1'b0;
      no_index       <= 1'b0;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], index};
      interval_valid <= measured;
      track_mark     <= track_mark_next;
      sector_pulse   <= sector_pulse_next;
      sector_num     <= sector_num_next;
      locked         <= locked_next;
      lock_lost      <= lock_lost_next;
      if (index_edge) begin
        timer      <= '0;
        first_seen <= 1'b1;
        no_index   <= 1'b0;
        if (first_seen) begin
          interval <= timer;
          history  <= history_next;
        end
      end else if (cke && (timer != TIMER_MAX)) begin
        timer <= timer + TIMER_ONE;
        if (saturating) no_index <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hard_sector_tracker.sv
// tb/tb_hard_sector_tracker.sv - scoreboard bench for hard_sector_tracker
module tb_hard_sector_tracker;

  localparam int TW = 8;
  localparam int SW = 6;
  localparam int SS = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cke = 1'b1;
  logic          index = 1'b0;
  logic [TW-1:0] threshold = 8'd50;
  logic [SW-1:0] sectors = 6'd4;
  logic [TW-1:0] interval;
  logic          interval_valid;
  logic          track_mark;
  logic          sector_pulse;
  logic [SW-1:0] sector_num;
  logic          locked;
  logic          lock_lost;
  logic          no_index;

  typedef struct packed {
    logic [TW-1:0] iv;
    logic          tm;
    logic          sp;
    logic [SW-1:0] sn;
    logic          lk;
    logic          ll;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   vectors = 0;
  int   errors = 0;
  int   stray = 0;
  int   sat_lost = 0;
  int   valid_seen = 0;
  int   pcount = 0;
  logic cke_div = 1'b0;

  always #5 clock = ~clock;

  hard_sector_tracker #(.TIMER_WIDTH(TW), .SECTOR_WIDTH(SW), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .cke(cke), .index(index),
    .threshold(threshold), .sectors(sectors),
    .interval(interval), .interval_valid(interval_valid),
    .track_mark(track_mark), .sector_pulse(sector_pulse),
    .sector_num(sector_num), .locked(locked),
    .lock_lost(lock_lost), .no_index(no_index)
  );

  // scoreboard: every interval_valid pops one expected edge record
  always @(negedge clock) begin
    if (reset) begin
      if (interval_valid) begin
        valid_seen++;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got interval=%0d required no event", interval);
        end else begin
          e_mon = exp_q.pop_front();
          if ({interval, track_mark, sector_pulse, sector_num, locked, lock_lost} !== e_mon) begin
            errors++;
            $display("FAIL edge_event got iv=%0d tm=%0b sp=%0b sn=%0d lk=%0b ll=%0b required iv=%0d tm=%0b sp=%0b sn=%0d lk=%0b ll=%0b",
                     interval, track_mark, sector_pulse, sector_num, locked, lock_lost,
                     e_mon.iv, e_mon.tm, e_mon.sp, e_mon.sn, e_mon.lk, e_mon.ll);
          end
        end
      end else if (track_mark || sector_pulse) begin
        stray++;
      end
      if (lock_lost && !interval_valid) sat_lost++;
    end
  end

  task automatic push(input int iv, input logic tm, input logic sp, input int sn,
                      input logic lk, input logic ll);
    exp_t e;
    e.iv = TW'(iv);
    e.tm = tm;
    e.sp = sp;
    e.sn = SW'(sn);
    e.lk = lk;
    e.ll = ll;
    exp_q.push_back(e);
  endtask

  // raise index for 2 cycles; the next raise comes d cycles after this one
  task automatic edge_at(input int d);
    for (int i = 0; i < d; i++) begin
      index = (i < 2);
      cke = cke_div ? (pcount % 4 == 0) : 1'b1;
      @(negedge clock);
      pcount++;
    end
    index = 1'b0;
  endtask

  function automatic int cke_expect(input int s0, input int d);
    int c = 0;
    for (int p = s0 + 3; p <= s0 + d + 1; p++) if (p % 4 == 0) c++;
    return c;
  endfunction

  task automatic do_reset();
    index = 1'b0;
    cke = 1'b1;
    cke_div = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    index = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({interval, interval_valid, track_mark, sector_pulse, sector_num, locked, lock_lost, no_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got iv=%0d v=%0b tm=%0b sp=%0b sn=%0d lk=%0b ll=%0b ni=%0b required all 0",
               interval, interval_valid, track_mark, sector_pulse, sector_num, locked, lock_lost, no_index);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_acquire();
    do_reset();
    edge_at(101);
    push(100, 0, 0, 0, 0, 0); edge_at(101);
    push(100, 0, 0, 0, 0, 0); edge_at(51);
    push(50,  0, 0, 0, 0, 0); edge_at(51);
    push(50,  1, 1, 0, 1, 0); edge_at(101);
    push(100, 0, 1, 1, 1, 0); edge_at(101);
    push(100, 0, 1, 2, 1, 0); edge_at(101);
    push(100, 0, 1, 3, 1, 0); edge_at(51);
    push(50,  0, 0, 3, 1, 0); edge_at(51);
    push(50,  1, 1, 0, 1, 0); edge_at(10);
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL acquire_drain got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_threshold();
    do_reset();
    edge_at(52);
    push(51, 0, 0, 0, 0, 0); edge_at(52);
    push(51, 0, 0, 0, 0, 0); edge_at(52);
    push(51, 0, 0, 0, 0, 0); edge_at(51);
    push(50, 0, 0, 0, 0, 0); edge_at(51);
    push(50, 1, 1, 0, 1, 0); edge_at(10);
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL threshold_drain got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_missing_index();
    do_reset();
    edge_at(101);
    push(100, 0, 0, 0, 0, 0); edge_at(51);
    push(50,  0, 0, 0, 0, 0); edge_at(51);
    push(50,  1, 1, 0, 1, 0); edge_at(101);
    push(100, 0, 1, 1, 1, 0); edge_at(101);
    push(100, 0, 1, 2, 1, 0); edge_at(101);
    push(100, 0, 1, 3, 1, 0); edge_at(101);
    push(100, 0, 0, 0, 0, 1); edge_at(51);
    push(50,  0, 0, 0, 0, 0); edge_at(51);
    push(50,  1, 1, 0, 1, 0); edge_at(10);
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL missing_index_drain got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    edge_at(101);
    push(100, 0, 0, 0, 0, 0); edge_at(51);
    push(50,  0, 0, 0, 0, 0); edge_at(51);
    push(50,  1, 1, 0, 1, 0); edge_at(3);
    n = 0;
    while (lock_lost !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n !== 255) begin
      errors++;
      $display("FAIL timeout_cycles got %0d required 255", n);
    end
    vectors++;
    if ({no_index, locked, sector_num, track_mark, sector_pulse} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_state got ni=%0b lk=%0b sn=%0d tm=%0b sp=%0b required ni=1 lk=0 sn=0 tm=0 sp=0",
               no_index, locked, sector_num, track_mark, sector_pulse);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if ({no_index, lock_lost} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_hold got ni=%0b ll=%0b required ni=1 ll=0", no_index, lock_lost);
    end
    push(255, 0, 0, 0, 0, 0); edge_at(3);
    vectors++;
    if (no_index !== 1'b0) begin
      errors++;
      $display("FAIL no_index_clear got %0b required 0", no_index);
    end
    repeat (5) @(negedge clock);
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_drain got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_cke();
    int sp[4] = '{400, 401, 402, 403};
    int s_prev;
    do_reset();
    cke_div = 1'b1;
    s_prev = pcount;
    edge_at(sp[0]);
    for (int k = 1; k < 4; k++) begin
      push(cke_expect(s_prev, sp[k-1]), 0, 0, 0, 0, 0);
      s_prev = pcount;
      edge_at(sp[k]);
    end
    cke_div = 1'b0;
    cke = 1'b1;
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL cke_drain got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_track();
    int v0;
    do_reset();
    edge_at(101);
    push(100, 0, 0, 0, 0, 0); edge_at(51);
    push(50,  0, 0, 0, 0, 0); edge_at(51);
    push(50,  1, 1, 0, 1, 0); edge_at(101);
    push(100, 0, 1, 1, 1, 0); edge_at(101);
    push(100, 0, 1, 2, 1, 0); edge_at(10);
    vectors++;
    if ({sector_num, locked} !== {6'd2, 1'b1}) begin
      errors++;
      $display("FAIL mid_track_pos got sn=%0d lk=%0b required sn=2 lk=1", sector_num, locked);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({interval, interval_valid, track_mark, sector_pulse, sector_num, locked, lock_lost, no_index} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got iv=%0d v=%0b tm=%0b sp=%0b sn=%0d lk=%0b ll=%0b ni=%0b required all 0",
               interval, interval_valid, track_mark, sector_pulse, sector_num, locked, lock_lost, no_index);
    end
    reset = 1'b1;
    v0 = valid_seen;
    edge_at(101);
    vectors++;
    if (valid_seen !== v0) begin
      errors++;
      $display("FAIL first_edge_valid got %0d strobes required 0", valid_seen - v0);
    end
    push(100, 0, 0, 0, 0, 0); edge_at(10);
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL mid_reset_drain got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_threshold();
    test_missing_index();
    test_timeout();
    test_cke();
    test_reset_mid_track();
    vectors++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL stray_strobes got %0d required 0", stray);
    end
    vectors++;
    if (sat_lost !== 1) begin
      errors++;
      $display("FAIL saturation_lock_lost got %0d required 1", sat_lost);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hard_sector_tracker.md
Name: hard_sector_tracker

Overview:
- Successor to the hard-sector track-mark detector.
- Measures the interval between hole pulses and classifies each interval as long or short against a threshold.
- Detects the track mark, which is one long interval followed by two short intervals.
- After the mark, counts sectors around the track, checks for the index hole at the expected position, and reports lock, lock loss and missing-index conditions.
- Everything runs in the single clock domain; the index input is only sampled through the synchroniser. Feeds the sector-timing and acquisition logic.

Parameters:
TIMER_WIDTH, 16, width of interval timer, threshold and interval outputs
SECTOR_WIDTH, 6, width of sector count and sector number
SYNC_STAGES, 3, index synchroniser depth (minimum 3)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous reset, active-low
cke  in  1  timebase enable; the timer advances only when high
index  in  1  raw hole/index pulse, active high, asynchronous
threshold  in  TIMER_WIDTH  an interval <= threshold is short
sectors  in  SECTOR_WIDTH  hard sectors per track (N >= 2); held stable while locked
interval  out  TIMER_WIDTH  last measured interval
interval_valid  out  1  one-cycle strobe when interval updates
track_mark  out  1  one-cycle strobe on track-mark detection
sector_pulse  out  1  one-cycle strobe at each sector hole while locked
sector_num  out  SECTOR_WIDTH  current sector, 0..N-1
locked  out  1  level, sector tracking valid
lock_lost  out  1  one-cycle strobe when lock is dropped
no_index  out  1  level, timer saturated (no hole seen)

Behaviour:
- Reset (reset==0 at a rising edge):
  - All outputs go to 0.
  - Timer is 0, state is SEARCH, the first-edge flag is cleared, and the class history is cleared to short.
  - Reset overrides everything, including in mid-track.
- Synchroniser and edge detection:
  - index passes through a SYNC_STAGES flop chain.
  - The edge strobe is asserted when the second-last stage is 1 and the last stage is 0.
  - Registered outputs update on the SYNC_STAGES-th clock edge after index is first sampled high.
  - A pulse held high produces exactly one edge.
- Timer:
  - On an edge: interval <= timer, timer <= 0; cke is ignored in that cycle.
  - Otherwise, if cke is high and the timer is below all-ones, the timer increments. The timer saturates at all-ones.
  - With cke=1 and edges D clocks apart, interval = D-1.
- First edge after reset: restarts the timer and sets the first-edge flag only. There is no interval_valid and no classification.
- Every later edge:
  - interval_valid pulses.
  - Class = short if interval <= threshold (unsigned), else long. A saturated interval is always long.
  - The class is shifted into a 3-deep history.
- no_index:
  - Set when the timer reaches all-ones.
  - Cleared on the next edge.
- FSM, evaluated on edge strobes only:
  - SEARCH:
    - If history is (long, short, short), oldest first: sector_num <= 0, track_mark=1, sector_pulse=1, locked <= 1, go to LOCKED.
    - Otherwise stay in SEARCH.
  - LOCKED, long interval, sector_num < N-1: sector_num <= sector_num+1, sector_pulse=1.
  - LOCKED, short interval, sector_num == N-1: go to INDEX. This is the index hole, so no sector_pulse and sector_num is held.
  - LOCKED, any other case (long at N-1, or short below N-1): go to lose-lock.
  - INDEX, short interval: sector_num <= 0, track_mark=1, sector_pulse=1, go to LOCKED.
  - INDEX, long interval: go to lose-lock.
  - lose-lock: locked <= 0, lock_lost=1, sector_num <= 0, go to SEARCH.
    - The class history is kept, so a fresh mark can be acquired from the existing history.
  - Timer saturation while in LOCKED or INDEX also causes lose-lock, in the saturation cycle; the timer stays saturated.
- Strobes:
  - All strobes last exactly one clock and are registered.
  - A lose-lock transition never asserts track_mark or sector_pulse in the same cycle.
- Width rules:
  - sector_num wraps only via explicit reset to 0 and never exceeds N-1.
  - Comparisons against N-1 are done at SECTOR_WIDTH; N is taken as unsigned.

Test Plan:
- Acquire: N=4, threshold=50, cke=1. Edge spacing 101,101,51,51,101,101,101,51,51 clocks.
  - Every edge after the first gives interval_valid; the intervals are 100,100,50,50,100,100,100,50,50.
  - After the 5th edge (its interval 50 completes long, short, short): track_mark and sector_pulse, sector_num=0, locked=1.
  - The next edges step sector_num 1,2,3.
  - The following short edge is the index hole: no pulse.
  - The next short edge gives track_mark with sector_num=0.
- Threshold boundary: spacing 52 gives interval 51, classified long, so no lock. Spacing 51 gives interval 50, classified short.
- Missing index hole: while locked with N=4, send a long interval at sector_num=3 -> lock_lost pulse, locked=0, sector_num=0. Then re-acquire on the next long, short, short pattern.
- Timeout: TIMER_WIDTH=8, locked, index held low -> the timer saturates at 255, then no_index=1 and lock_lost in the same cycle. The next edge clears no_index.
- cke gating: cke high 1 cycle in 4, edges 400 clocks apart -> interval = 99 or 100 depending on cke phase. Bench checks against a model.
- Reset mid-track: assert reset for one clock at sector_num=2 -> all outputs 0 next cycle. The first subsequent edge produces no interval_valid.
